// File: rtl/dmg_timer_pkg.sv
// Shared types and constants for the DMG DIV/TIMA/TMA/TAC timer.
package dmg_timer_pkg;

    typedef enum logic [1:0] {REG_DIV, REG_TIMA, REG_TMA, REG_TAC} timer_reg_e;

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_RELOAD} reload_state_e;

    // Divider bit watched for each TAC clock-select code.
    localparam int TAC_TAP[4] = '{9, 3, 5, 7};

    localparam logic [4:0] TAC_RD_ONES = 5'h1F;

endpackage

// File: rtl/dmg_timer_if.sv
// CPU-side register bus of the timer plus its interrupt request line.
interface dmg_timer_if;
    logic       wr_en;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq_timer;

    modport master (output wr_en, addr, wdata, input rdata, irq_timer);
    modport slave  (input wr_en, addr, wdata, output rdata, irq_timer);
endinterface

// File: rtl/dmg_timer_div.sv
// Free-running T-cycle divider with TAC tap select and falling-edge detector.
module dmg_timer_div
    import dmg_timer_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_div_clr,
    input  logic [2:0] i_tac_next,
    output logic [7:0] o_div_hi,
    output logic       o_tima_inc
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic [3:0]       w_taps;
    logic             w_tick_next;
    logic             r_tick_prev;

    assign w_div_next = i_div_clr ? '0 : r_div + DIV_ONE;

    for (genvar gi = 0; gi < 4; gi++) begin : g_tap
        assign w_taps[gi] = w_div_next[TAC_TAP[gi]];
    end

    // The edge is judged on post-update div/tac so DIV clears and TAC
    // changes that pull the tap low produce the hardware's spurious tick.
    assign w_tick_next = i_tac_next[2] & w_taps[i_tac_next[1:0]];
    assign o_tima_inc  = r_tick_prev & ~w_tick_next;
    assign o_div_hi    = r_div[DIV_W-1 -: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div       <= '0;
            r_tick_prev <= 1'b0;
        end else begin
            r_div       <= w_div_next;
            r_tick_prev <= w_tick_next;
        end
    end

endmodule

// File: rtl/dmg_timer.sv
// DMG timer top: TIMA/TMA/TAC registers, delayed TMA reload with IRQ pulse, read mux.
module dmg_timer
    import dmg_timer_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int RELOAD_DLY = 4
) (
    input  logic        clk,
    input  logic        reset,
    dmg_timer_if.slave  bus
);

    localparam int               CNT_W    = $clog2(RELOAD_DLY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RELOAD_DLY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    timer_reg_e    w_sel;
    logic          w_wr_div, w_wr_tima, w_wr_tma, w_wr_tac;
    logic [2:0]    w_tac_next;
    logic [7:0]    w_tma_next;
    logic [7:0]    w_div_hi;
    logic          w_tima_inc;
    logic          w_reload;
    logic          w_overflow;
    logic [7:0]    w_rdata;

    logic [7:0]    r_tima;
    logic [7:0]    r_tma;
    logic [2:0]    r_tac;
    logic [CNT_W-1:0] r_cnt;
    reload_state_e r_state;
    logic          r_irq;

    assign w_sel      = timer_reg_e'(bus.addr);
    assign w_wr_div   = bus.wr_en && (w_sel == REG_DIV);
    assign w_wr_tima  = bus.wr_en && (w_sel == REG_TIMA);
    assign w_wr_tma   = bus.wr_en && (w_sel == REG_TMA);
    assign w_wr_tac   = bus.wr_en && (w_sel == REG_TAC);
    assign w_tac_next = w_wr_tac ? bus.wdata[2:0] : r_tac;
    assign w_tma_next = w_wr_tma ? bus.wdata : r_tma;

    dmg_timer_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .i_div_clr  (w_wr_div),
        .i_tac_next (w_tac_next),
        .o_div_hi   (w_div_hi),
        .o_tima_inc (w_tima_inc)
    );

    // The reload edge beats a same-cycle TIMA write; a same-cycle TMA write
    // is what gets loaded.
    assign w_reload   = (r_state == ST_DELAY) && (r_cnt == CNT_LAST);
    assign w_overflow = !w_reload && !w_wr_tima && w_tima_inc && (r_tima == 8'hFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tima  <= 8'h00;
            r_tma   <= 8'h00;
            r_tac   <= 3'b000;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
        end else begin
            r_tma <= w_tma_next;
            r_tac <= w_tac_next;
            r_irq <= w_reload;

            if (w_reload)
                r_tima <= w_tma_next;
            else if (w_wr_tima)
                r_tima <= bus.wdata;
            else if (w_tima_inc)
                r_tima <= r_tima + 8'd1;

            if (w_reload) begin
                r_state <= ST_RELOAD;
                r_cnt   <= '0;
            end else if (w_overflow) begin
                r_state <= ST_DELAY;
                r_cnt   <= CNT_INIT;
            end else if (r_state == ST_DELAY) begin
                if (w_wr_tima) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt - CNT_LAST;
                end
            end else if (r_state == ST_RELOAD) begin
                r_state <= ST_IDLE;
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (w_sel)
            REG_DIV:  w_rdata = w_div_hi;
            REG_TIMA: w_rdata = r_tima;
            REG_TMA:  w_rdata = r_tma;
            default:  w_rdata = {TAC_RD_ONES, r_tac};
        endcase
    end

    assign bus.rdata     = w_rdata;
    assign bus.irq_timer = r_irq;

endmodule

// File: tb/tb_dmg_timer.sv
// Directed self-checking bench for dmg_timer; tracks the divider count to place writes.
module tb_dmg_timer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   div_m;
    int   d_ovf;

    dmg_timer_if bus ();

    dmg_timer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (div=%0d)", tag, got, exp, div_m);
        end else begin
            $display("ok   %s = %h (div=%0d)", tag, got, div_m);
        end
    endtask

    // One clock; div_m follows the divider as the DUT should see it.
    task automatic step();
        logic clr;
        clr = reset || (bus.wr_en && bus.addr == 2'd0);
        @(posedge clk);
        div_m = clr ? 0 : ((div_m + 1) & 16'hFFFF);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (div_m != target && n < 70000) begin
            step();
            n++;
        end
        if (n >= 70000) check_eq("run_to_budget", div_m[15:0], target[15:0]);
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        bus.addr = a;
        #1;
        check_eq(tag, {8'h00, bus.rdata}, {8'h00, exp});
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check_eq(tag, {15'h0, bus.irq_timer}, {15'h0, exp});
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        div_m     = 0;
        reset     = 1'b1;
        bus.wr_en = 1'b0;
        bus.addr  = 2'd0;
        bus.wdata = 8'h00;

        // Reset state
        repeat (3) step();
        reset = 1'b0;
        chk_reg("rst_div", 2'd0, 8'h00);
        chk_reg("rst_tima", 2'd1, 8'h00);
        chk_reg("rst_tma", 2'd2, 8'h00);
        chk_reg("rst_tac", 2'd3, 8'hF8);
        chk_irq("rst_irq", 1'b0);

        // Basic counting, overflow, delayed reload
        wr(2'd3, 8'h05);
        wr(2'd2, 8'hA5);
        run_to(16);
        chk_reg("t1_first_inc", 2'd1, 8'h01);
        run_to(4080);
        chk_reg("t1_tima_ff", 2'd1, 8'hFF);
        run_to(4096);
        chk_reg("t1_div_read", 2'd0, 8'h10);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            chk_reg("t1_delay_tima", 2'd1, 8'h00);
            chk_irq("t1_delay_irq", 1'b0);
        end
        step();
        chk_reg("t1_reload_tima", 2'd1, 8'hA5);
        chk_irq("t1_reload_irq", 1'b1);
        step();
        chk_irq("t1_irq_drop", 1'b0);
        chk_reg("t1_after_tima", 2'd1, 8'hA5);

        // TIMA write during delay cancels reload
        wr(2'd2, 8'hFE);
        wr(2'd1, 8'hFF);
        d_ovf = (div_m | 15) + 1;
        run_to(d_ovf);
        chk_reg("t2_ovf_tima", 2'd1, 8'h00);
        step();
        wr(2'd1, 8'h42);
        chk_reg("t2_cancel_tima", 2'd1, 8'h42);
        for (int i = 0; i < 6; i++) begin
            chk_irq("t2_no_irq", 1'b0);
            step();
        end
        chk_reg("t2_still_42", 2'd1, 8'h42);

        // TMA write on the reload edge is loaded
        wr(2'd1, 8'hFF);
        d_ovf = (div_m | 15) + 1;
        run_to(d_ovf);
        run_to(d_ovf + 3);
        wr(2'd2, 8'h77);
        chk_reg("t3a_tima", 2'd1, 8'h77);
        chk_reg("t3a_tma", 2'd2, 8'h77);
        chk_irq("t3a_irq", 1'b1);
        step();
        chk_irq("t3a_irq_drop", 1'b0);

        // TIMA write on the reload edge is dropped
        wr(2'd1, 8'hFF);
        d_ovf = (div_m | 15) + 1;
        run_to(d_ovf);
        run_to(d_ovf + 3);
        wr(2'd1, 8'h11);
        chk_reg("t3b_tima", 2'd1, 8'h77);
        chk_irq("t3b_irq", 1'b1);
        step();
        chk_irq("t3b_irq_drop", 1'b0);
        chk_reg("t3b_after", 2'd1, 8'h77);

        // DIV write with tap high gives a spurious increment, tap low does not
        run_to(((div_m >> 4) + 1) * 16 + 8);
        chk_reg("t4_pre", 2'd1, 8'h78);
        wr(2'd0, 8'h5A);
        chk_reg("t4_div_clr", 2'd0, 8'h00);
        chk_reg("t4_spurious", 2'd1, 8'h79);
        run_to(2);
        wr(2'd0, 8'h00);
        chk_reg("t4_no_inc", 2'd1, 8'h79);

        // TAC write that disables a high tap increments TIMA
        wr(2'd3, 8'h07);
        run_to(128);
        chk_reg("t5_pre", 2'd1, 8'h79);
        wr(2'd3, 8'h03);
        chk_reg("t5_tac_read", 2'd3, 8'hFB);
        chk_reg("t5_spurious", 2'd1, 8'h7A);
        repeat (300) step();
        chk_reg("t5_disabled", 2'd1, 8'h7A);

        // Reset in the middle of the reload delay
        wr(2'd3, 8'h05);
        wr(2'd2, 8'h3C);
        wr(2'd1, 8'hFF);
        d_ovf = (div_m | 15) + 1;
        run_to(d_ovf);
        chk_reg("t6_ovf_tima", 2'd1, 8'h00);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reg("t6_div", 2'd0, 8'h00);
        chk_reg("t6_tima", 2'd1, 8'h00);
        chk_reg("t6_tma", 2'd2, 8'h00);
        chk_reg("t6_tac", 2'd3, 8'hF8);
        for (int i = 0; i < 8; i++) begin
            chk_irq("t6_no_irq", 1'b0);
            step();
        end
        chk_irq("t6_no_irq_end", 1'b0);
        chk_reg("t6_tima_end", 2'd1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
